// File: rtl/dpc_frame_ctrl.sv
// Frame timing and config controller for the 5x5 defect-pixel-correction datapath.
// Tracks pixel position, derives Bayer phase and window validity, shadows config.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   href_i, vsync_i  input line strobe and frame sync (rising edge = frame start)
//   cfg_we           one-cycle write of cfg_thresh/cfg_bayer/cfg_bypass into pending
//   thresh_o         active defect threshold
//   phase_o          Bayer phase of the current input pixel
//   win_valid_o      every tap of the 5x5 window holds a pixel of this frame
//   corr_en_o        window valid and correction not bypassed
//   href_o, vsync_o  sync inputs delayed LATENCY cycles
//   cfg_pending_o    a written config is waiting for the next frame start
//   frame_done_o     one-cycle pulse after the last line of a frame
//   err_o            sticky {frame_err, line_err}, cleared at frame start
module dpc_frame_ctrl #(
    parameter int BITS    = 8,
    parameter int WIDTH   = 2048,
    parameter int HEIGHT  = 2048,
    parameter int LATENCY = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            href_i,
    input  logic            vsync_i,
    input  logic            cfg_we,
    input  logic [BITS-1:0] cfg_thresh,
    input  logic [1:0]      cfg_bayer,
    input  logic            cfg_bypass,
    output logic [BITS-1:0] thresh_o,
    output logic [1:0]      phase_o,
    output logic            win_valid_o,
    output logic            corr_en_o,
    output logic            href_o,
    output logic            vsync_o,
    output logic            cfg_pending_o,
    output logic            frame_done_o,
    output logic [1:0]      err_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(HEIGHT + 1);

    localparam logic [CW-1:0] COL_MAX  = CW'(WIDTH);
    localparam logic [RW-1:0] ROW_MAX  = RW'(HEIGHT);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VBLANK,
        S_ACTIVE,
        S_HBLANK,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic href_d;
    logic vsync_d;
    logic vs_rise;
    logic h_rise;
    logic h_fall;
    logic in_frame;
    logic col_full;
    logic row_full;
    logic pix;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [BITS-1:0] thr_act;
    logic [BITS-1:0] thr_pnd;
    logic [1:0]      bay_act;
    logic [1:0]      bay_pnd;
    logic            byp_act;
    logic            byp_pnd;
    logic            pnd;

    logic line_err;
    logic frame_err;

    logic [LATENCY-1:0] href_sr;
    logic [LATENCY-1:0] vsync_sr;

    assign vs_rise  = vsync_i & ~vsync_d;
    assign h_rise   = href_i & ~href_d;
    assign h_fall   = ~href_i & href_d;
    assign in_frame = (state == S_VBLANK) || (state == S_ACTIVE)
                   || (state == S_HBLANK);
    assign col_full = (col == COL_MAX);
    assign row_full = (row == ROW_MAX);
    // Lines arriving after the last row of a frame are ignored.
    assign pix      = href_i & in_frame & ~row_full;

    // Saturated column means the line overran WIDTH: window is no longer trusted.
    assign win_valid_o = pix & (32'(row) >= 32'd4) & (32'(col) >= 32'd4)
                       & ~col_full;
    assign corr_en_o   = win_valid_o & ~byp_act;
    assign phase_o     = pix ? (bay_act ^ {row[0], col[0]}) : 2'b00;

    assign thresh_o      = thr_act;
    assign cfg_pending_o = pnd;
    assign err_o         = {frame_err, line_err};
    assign href_o        = href_sr[LATENCY-1];
    assign vsync_o       = vsync_sr[LATENCY-1];

    always_comb begin
        state_nxt    = state;
        frame_done_o = 1'b0;
        unique case (state)
            S_IDLE:   state_nxt = S_IDLE;
            S_VBLANK: if (href_i) state_nxt = S_ACTIVE;
            S_ACTIVE: if (h_fall) state_nxt = (row == ROW_LAST) ? S_DONE : S_HBLANK;
            S_HBLANK: if (href_i) state_nxt = S_ACTIVE;
            S_DONE: begin
                frame_done_o = 1'b1;
                state_nxt    = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
        if (vs_rise) state_nxt = S_VBLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            href_d  <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            state   <= state_nxt;
            href_d  <= href_i;
            vsync_d <= vsync_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (vs_rise) begin
            col <= '0;
            row <= '0;
        end else if (in_frame) begin
            if (h_fall) begin
                col <= '0;
                if (!row_full) row <= row + RW'(1);
            end else if (pix && !col_full) begin
                col <= col + CW'(1);
            end
        end
    end

    // An unfinished frame is flagged as it is restarted, so frame_err
    // survives the clear that every frame start performs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_err  <= 1'b0;
            frame_err <= 1'b0;
        end else if (vs_rise) begin
            line_err  <= 1'b0;
            frame_err <= in_frame;
        end else begin
            if (in_frame && href_i && col_full) line_err <= 1'b1;
            if (h_rise && row_full)             frame_err <= 1'b1;
        end
    end

    // A write coinciding with frame start goes straight to the active copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_act <= '0;
            bay_act <= '0;
            byp_act <= 1'b0;
            thr_pnd <= '0;
            bay_pnd <= '0;
            byp_pnd <= 1'b0;
            pnd     <= 1'b0;
        end else if (vs_rise) begin
            if (cfg_we) begin
                thr_act <= cfg_thresh;
                bay_act <= cfg_bayer;
                byp_act <= cfg_bypass;
                pnd     <= 1'b0;
            end else if (pnd) begin
                thr_act <= thr_pnd;
                bay_act <= bay_pnd;
                byp_act <= byp_pnd;
                pnd     <= 1'b0;
            end
        end else if (cfg_we) begin
            thr_pnd <= cfg_thresh;
            bay_pnd <= cfg_bayer;
            byp_pnd <= cfg_bypass;
            pnd     <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_sr  <= '0;
            vsync_sr <= '0;
        end else begin
            href_sr[0]  <= href_i;
            vsync_sr[0] <= vsync_i;
            for (int i = 1; i < LATENCY; i++) begin
                href_sr[i]  <= href_sr[i-1];
                vsync_sr[i] <= vsync_sr[i-1];
            end
        end
    end

endmodule
